// File: rtl/fpu_pe_collector_pkg.sv
// Shared FPU types: per-lane exception flag struct and the masked flag-merge helper.
package fpu_pe_collector_pkg;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam int unsigned FFLAGS_W = $bits(fflags_t);

    // One step of a masked OR reduction; callers fold this over their lanes.
    function automatic fflags_t merge_fflags(fflags_t acc, fflags_t flags, logic en);
        return en ? fflags_t'(acc | flags) : acc;
    endfunction

endpackage

// File: rtl/fpu_pe_collector_buf.sv
// Elastic single-entry buffer: registered valid/data, accepts new data while draining.
module fpu_pe_collector_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        in_ready_o = !valid_q || out_ready_i;
        valid_d    = valid_q;
        data_d     = data_q;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/fpu_pe_collector.sv
// Reassembles NUM_PES-wide PE beats into one NUM_LANES-wide FPU result with tag, mask and
// merged exception flags, presented through a valid/ready output register.
module fpu_pe_collector
    import fpu_pe_collector_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned NUM_PES     = 1,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FLAGS_WIDTH = 5,
    parameter int unsigned TAG_WIDTH   = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            pe_valid_in,
    output logic                            pe_ready_in,
    input  logic [NUM_PES*DATA_WIDTH-1:0]   pe_data_in,
    input  logic [NUM_PES*FLAGS_WIDTH-1:0]  pe_fflags_in,
    input  logic [NUM_LANES-1:0]            pe_mask_in,
    input  logic [TAG_WIDTH-1:0]            pe_tag_in,
    output logic                            valid_out,
    input  logic                            ready_out,
    output logic [NUM_LANES*DATA_WIDTH-1:0] result,
    output logic [FLAGS_WIDTH-1:0]          fflags,
    output logic [NUM_LANES-1:0]            mask_out,
    output logic [TAG_WIDTH-1:0]            tag_out
);

    localparam int unsigned BATCHES   = NUM_LANES / NUM_PES;
    localparam int unsigned CNT_W     = (BATCHES > 1) ? $clog2(BATCHES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BATCHES - 1);
    localparam int unsigned PAYLOAD_W = TAG_WIDTH + NUM_LANES + FLAGS_WIDTH
                                        + NUM_LANES * DATA_WIDTH;

    if ((NUM_LANES % NUM_PES) != 0 || FLAGS_WIDTH != FFLAGS_W) begin : g_bad_cfg
        $error("fpu_pe_collector: NUM_LANES must be a multiple of NUM_PES, FLAGS_WIDTH == 5");
    end

    typedef enum logic [0:0] {StCollect, StLast} state_e;

    state_e                          state;
    logic [CNT_W-1:0]                batch_cnt_q, batch_cnt_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] asm_data_q, asm_data_d;
    logic [NUM_LANES-1:0]            asm_mask_q, asm_mask_d;
    logic [TAG_WIDTH-1:0]            asm_tag_q, asm_tag_d;
    fflags_t                         asm_flags_q, asm_flags_d;
    logic                            first_beat, beat_fire;
    logic                            buf_in_valid, buf_in_ready;
    logic [PAYLOAD_W-1:0]            buf_in_data, buf_out_data;

    always_comb begin
        state       = (batch_cnt_q == LAST_CNT) ? StLast : StCollect;
        first_beat  = (batch_cnt_q == '0);
        pe_ready_in = (state == StLast) ? buf_in_ready : 1'b1;
        beat_fire   = pe_valid_in && pe_ready_in;

        batch_cnt_d = batch_cnt_q;
        if (beat_fire) begin
            batch_cnt_d = (state == StLast) ? '0 : batch_cnt_q + CNT_W'(1);
        end

        // Next assembly contents include the current beat so the last beat can load the
        // output register directly without an extra cycle.
        asm_data_d  = asm_data_q;
        asm_mask_d  = first_beat ? pe_mask_in : asm_mask_q;
        asm_tag_d   = first_beat ? pe_tag_in : asm_tag_q;
        asm_flags_d = first_beat ? fflags_t'('0) : asm_flags_q;
        for (int unsigned i = 0; i < NUM_PES; i++) begin
            int unsigned lane;
            lane = 32'(batch_cnt_q) * NUM_PES + i;
            asm_data_d[lane*DATA_WIDTH +: DATA_WIDTH] = pe_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            asm_flags_d = merge_fflags(asm_flags_d,
                                       fflags_t'(pe_fflags_in[i*FLAGS_WIDTH +: FLAGS_WIDTH]),
                                       pe_mask_in[lane]);
        end

        buf_in_valid = pe_valid_in && (state == StLast);
        buf_in_data  = {asm_tag_d, asm_mask_d, asm_flags_d, asm_data_d};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            batch_cnt_q <= '0;
            asm_data_q  <= '0;
            asm_mask_q  <= '0;
            asm_tag_q   <= '0;
            asm_flags_q <= '0;
        end else if (beat_fire) begin
            batch_cnt_q <= batch_cnt_d;
            asm_data_q  <= asm_data_d;
            asm_mask_q  <= asm_mask_d;
            asm_tag_q   <= asm_tag_d;
            asm_flags_q <= asm_flags_d;
        end
    end

    fpu_pe_collector_buf #(
        .WIDTH(PAYLOAD_W)
    ) u_out_buf (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .in_valid_i (buf_in_valid),
        .in_ready_o (buf_in_ready),
        .in_data_i  (buf_in_data),
        .out_valid_o(valid_out),
        .out_ready_i(ready_out),
        .out_data_o (buf_out_data)
    );

    assign {tag_out, mask_out, fflags, result} = buf_out_data;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!$isunknown(pe_valid_in) && !$isunknown(ready_out));
            if (pe_valid_in && !first_beat) begin
                assert (pe_tag_in == asm_tag_q && pe_mask_in == asm_mask_q);
            end
        end
    end

endmodule

// File: tb/tb_fpu_pe_collector.sv
// Directed bench for fpu_pe_collector in 4/1, 4/2 and 4/4 lane/PE configurations.
module tb_fpu_pe_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic         a_pv, a_pr, a_vo, a_ro, a_pt, a_to;
    logic [31:0]  a_pd;
    logic [4:0]   a_pf, a_ff;
    logic [3:0]   a_pm, a_mo;
    logic [127:0] a_res;

    logic         b_pv, b_pr, b_vo, b_ro, b_pt, b_to;
    logic [63:0]  b_pd;
    logic [9:0]   b_pf;
    logic [4:0]   b_ff;
    logic [3:0]   b_pm, b_mo;
    logic [127:0] b_res;

    logic         c_pv, c_pr, c_vo, c_ro, c_pt, c_to;
    logic [127:0] c_pd;
    logic [19:0]  c_pf;
    logic [4:0]   c_ff;
    logic [3:0]   c_pm, c_mo;
    logic [127:0] c_res;

    fpu_pe_collector #(.NUM_LANES(4), .NUM_PES(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .pe_valid_in(a_pv), .pe_ready_in(a_pr),
        .pe_data_in(a_pd), .pe_fflags_in(a_pf), .pe_mask_in(a_pm), .pe_tag_in(a_pt),
        .valid_out(a_vo), .ready_out(a_ro), .result(a_res), .fflags(a_ff),
        .mask_out(a_mo), .tag_out(a_to)
    );

    fpu_pe_collector #(.NUM_LANES(4), .NUM_PES(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .pe_valid_in(b_pv), .pe_ready_in(b_pr),
        .pe_data_in(b_pd), .pe_fflags_in(b_pf), .pe_mask_in(b_pm), .pe_tag_in(b_pt),
        .valid_out(b_vo), .ready_out(b_ro), .result(b_res), .fflags(b_ff),
        .mask_out(b_mo), .tag_out(b_to)
    );

    fpu_pe_collector #(.NUM_LANES(4), .NUM_PES(4)) dut_c (
        .clk(clk), .reset_n(reset_n), .pe_valid_in(c_pv), .pe_ready_in(c_pr),
        .pe_data_in(c_pd), .pe_fflags_in(c_pf), .pe_mask_in(c_pm), .pe_tag_in(c_pt),
        .valid_out(c_vo), .ready_out(c_ro), .result(c_res), .fflags(c_ff),
        .mask_out(c_mo), .tag_out(c_to)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_beat(input logic [31:0] d, input logic [4:0] f, input logic [3:0] m,
                          input logic t);
        a_pv = 1'b1; a_pd = d; a_pf = f; a_pm = m; a_pt = t;
        #1;
        check_eq("a_pe_ready", a_pr, 1);
        tick();
        a_pv = 1'b0;
    endtask

    task automatic b_beat(input logic [63:0] d, input logic [9:0] f, input logic [3:0] m,
                          input logic t);
        b_pv = 1'b1; b_pd = d; b_pf = f; b_pm = m; b_pt = t;
        #1;
        check_eq("b_pe_ready", b_pr, 1);
        tick();
        b_pv = 1'b0;
    endtask

    function automatic logic [127:0] c_word(input int r);
        logic [127:0] w;
        for (int l = 0; l < 4; l++) w[l*32 +: 32] = 32'((r << 8) | l);
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] exp_q[$];
        int           n;
        int           seen;

        reset_n = 1'b0;
        a_pv = 0; a_pd = 0; a_pf = 0; a_pm = 0; a_pt = 0; a_ro = 1;
        b_pv = 0; b_pd = 0; b_pf = 0; b_pm = 0; b_pt = 0; b_ro = 1;
        c_pv = 0; c_pd = 0; c_pf = 0; c_pm = 0; c_pt = 0; c_ro = 1;
        repeat (2) tick();
        check_eq("rst_a_valid", a_vo, 0);
        check_eq("rst_a_result", a_res, 0);
        check_eq("rst_a_tag", a_to, 0);
        check_eq("rst_a_ready", a_pr, 1);
        check_eq("rst_c_ready", c_pr, 1);
        reset_n = 1'b1;
        tick();

        // Basic 4/1 assembly; lane 3 raises OF under a full mask.
        a_beat(32'h10, 5'b00000, 4'b1111, 1'b1);
        a_beat(32'h11, 5'b00000, 4'b1111, 1'b1);
        a_beat(32'h12, 5'b00000, 4'b1111, 1'b1);
        check_eq("t1_not_early", a_vo, 0);
        a_beat(32'h13, 5'b00100, 4'b1111, 1'b1);
        check_eq("t1_valid", a_vo, 1);
        check_eq("t1_result", a_res, 128'h00000013_00000012_00000011_00000010);
        check_eq("t1_tag", a_to, 1);
        check_eq("t1_mask", a_mo, 4'b1111);
        check_eq("t1_fflags", a_ff, 5'b00100);
        tick();
        check_eq("t1_drained", a_vo, 0);

        // Flag masking: lane1 NV is masked off, lane2 NX counts.
        a_beat(32'h20, 5'b00000, 4'b0101, 1'b0);
        a_beat(32'h21, 5'b10000, 4'b0101, 1'b0);
        a_beat(32'h22, 5'b00001, 4'b0101, 1'b0);
        a_beat(32'h23, 5'b00000, 4'b0101, 1'b0);
        check_eq("t2_valid", a_vo, 1);
        check_eq("t2_fflags", a_ff, 5'b00001);
        check_eq("t2_mask", a_mo, 4'b0101);
        check_eq("t2_tag", a_to, 0);
        check_eq("t2_result", a_res, 128'h00000023_00000022_00000021_00000020);
        tick();

        // Reset discards a partial request.
        a_beat(32'hAA, 5'b00000, 4'b1111, 1'b1);
        a_beat(32'hBB, 5'b00000, 4'b1111, 1'b1);
        reset_n = 1'b0;
        tick();
        check_eq("t3_rst_valid", a_vo, 0);
        check_eq("t3_rst_result", a_res, 0);
        check_eq("t3_rst_ready", a_pr, 1);
        reset_n = 1'b1;
        a_beat(32'h30, 5'b00000, 4'b1111, 1'b0);
        a_beat(32'h31, 5'b00000, 4'b1111, 1'b0);
        a_beat(32'h32, 5'b00000, 4'b1111, 1'b0);
        a_beat(32'h33, 5'b00000, 4'b1111, 1'b0);
        check_eq("t3_valid", a_vo, 1);
        check_eq("t3_result", a_res, 128'h00000033_00000032_00000031_00000030);
        check_eq("t3_tag", a_to, 0);
        tick();

        // Idle gap between beats 1 and 2.
        a_beat(32'h40, 5'b00000, 4'b1111, 1'b1);
        a_beat(32'h41, 5'b00000, 4'b1111, 1'b1);
        repeat (3) begin
            tick();
            check_eq("t4_gap_valid", a_vo, 0);
            check_eq("t4_gap_ready", a_pr, 1);
        end
        a_beat(32'h42, 5'b00000, 4'b1111, 1'b1);
        check_eq("t4_not_early", a_vo, 0);
        a_beat(32'h43, 5'b00000, 4'b1111, 1'b1);
        check_eq("t4_valid", a_vo, 1);
        check_eq("t4_result", a_res, 128'h00000043_00000042_00000041_00000040);
        tick();

        // Backpressure on 4/2: B collects while A is stalled at the output.
        b_beat({32'h101, 32'h100}, 10'b0, 4'b1111, 1'b1);
        b_ro = 1'b0;
        b_beat({32'h103, 32'h102}, 10'b0, 4'b1111, 1'b1);
        check_eq("t5_a_valid", b_vo, 1);
        check_eq("t5_a_result", b_res, 128'h00000103_00000102_00000101_00000100);
        b_beat({32'h201, 32'h200}, {5'b00000, 5'b00010}, 4'b1010, 1'b0);
        check_eq("t5_a_hold", b_res, 128'h00000103_00000102_00000101_00000100);
        b_pv = 1'b1; b_pd = {32'h203, 32'h202}; b_pf = {5'b01000, 5'b00000};
        repeat (4) begin
            #1;
            check_eq("t5_stall_ready", b_pr, 0);
            tick();
            check_eq("t5_stall_valid", b_vo, 1);
            check_eq("t5_stall_result", b_res, 128'h00000103_00000102_00000101_00000100);
            check_eq("t5_stall_tag", b_to, 1);
        end
        b_ro = 1'b1;
        #1;
        check_eq("t5_release_ready", b_pr, 1);
        tick();
        b_pv = 1'b0;
        check_eq("t5_b_valid", b_vo, 1);
        check_eq("t5_b_result", b_res, 128'h00000203_00000202_00000201_00000200);
        check_eq("t5_b_fflags", b_ff, 5'b01000);
        check_eq("t5_b_mask", b_mo, 4'b1010);
        check_eq("t5_b_tag", b_to, 0);
        tick();
        check_eq("t5_drained", b_vo, 0);

        // Single-beat requests on 4/4, back to back.
        c_pm = 4'b1111;
        for (int r = 0; r < 8; r++) begin
            c_pv = 1'b1; c_pd = c_word(r); c_pt = r[0];
            #1;
            check_eq("t6_ready", c_pr, 1);
            tick();
            check_eq("t6_valid", c_vo, 1);
            check_eq("t6_result", c_res, c_word(r));
            check_eq("t6_tag", c_to, r[0]);
        end
        c_pv = 1'b0;
        tick();
        check_eq("t6_drained", c_vo, 0);

        // Toggling ready_out: every accepted request must come out once, in order.
        n = 8;
        seen = 0;
        for (int cyc = 0; cyc < 60 && seen < 8; cyc++) begin
            c_ro = cyc[0];
            c_pv = (n < 16);
            c_pd = c_word(n);
            c_pt = n[0];
            #1;
            if (c_vo && c_ro) begin
                if (exp_q.size() == 0) begin
                    check_eq("t7_spurious_out", c_vo, 0);
                end else begin
                    check_eq("t7_order", c_res, exp_q.pop_front());
                    seen++;
                end
            end
            if (c_pv && c_pr) begin
                exp_q.push_back(c_word(n));
                n++;
            end
            tick();
        end
        c_pv = 1'b0;
        c_ro = 1'b1;
        check_eq("t7_outputs_seen", 128'(seen), 8);
        check_eq("t7_queue_empty", 128'(exp_q.size()), 0);
        tick();
        check_eq("t7_drained", c_vo, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
